axis_fixed_divider: RTL
=======================

# axis_fixed_divider

Sequential signed fixed-point divider with AXI-stream-style valid/ready handshake. It serves the division requests issued by the 2x2 matrix inversion controller and the other Kalman-filter datapath blocks. It accepts a WIDTH-bit dividend and divisor and returns a 2·WIDTH-bit quotient in Q(WIDTH).(WIDTH) format: upper half integer, lower half fraction. Division is bit-serial restoring long division with fixed latency. This block replaces the vendor divider core in the filter datapath.

## Interface
- WIDTH, 16, operand width; result width is 2·WIDTH.
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- clk_en  in  1  global clock enable; state advances and handshakes complete only when 1.
- s_axis_dividend_tdata  in  WIDTH  two's-complement dividend.
- s_axis_dividend_tvalid  in  1  dividend valid.
- s_axis_divisor_tdata  in  WIDTH  two's-complement divisor.
- s_axis_divisor_tvalid  in  1  divisor valid.
- s_axis_tready  out  1  high only in IDLE with rst_n=1; shared by both input channels.
- m_axis_dout_tdata  out  2·WIDTH  signed quotient, Q(WIDTH).(WIDTH); reset 0.
- m_axis_dout_tuser  out  2  {div_by_zero, overflow}; reset 0.
- m_axis_dout_tvalid  out  1  one-cycle result strobe; reset 0. No backpressure.

## Operation
- Accept occurs at an enabled edge when dividend_tvalid, divisor_tvalid and tready are all 1. Both tvalids are required; a single tvalid is ignored.
- On accept, the block registers the sign of the result (sign(a) XOR sign(b)), |a|, |b| (WIDTH-bit unsigned, so |0x8000| = 0x8000), div_by_zero = (b==0), and the dividend sign.
- FSM states are IDLE, CALC, FIX and DONE.
  - IDLE→CALC on accept.
  - CALC runs 2·WIDTH iterations, one quotient bit per enabled cycle, over the numerator |a|·2^WIDTH. The remainder register is WIDTH+1 bits. CALC→FIX after the last iteration.
  - FIX→DONE: the block forms the signed result and flags and registers tdata/tuser.
  - DONE→IDLE: tvalid is high only while in DONE.
- Result rules, with M the 2·WIDTH-bit magnitude, truncated toward zero:
  - Positive result: if M ≥ 2^(2W−1), output 0x7FFF_FFFF and overflow=1; otherwise output M.
  - Negative result: if M > 2^(2W−1), output 0x8000_0000 and overflow=1; otherwise output −M.
  - Divide by zero (overrides overflow): 0x7FFF_FFFF if the dividend ≥ 0, else 0x8000_0000; tuser=2'b10. 0/0 yields 0x7FFF_FFFF.
- tdata/tuser hold their last result until the next FIX.
- Inputs are not sampled outside the accept edge. Changing operands during CALC has no effect.

## Timing
- Latency is fixed regardless of operands, including divide-by-zero.
- If the accept happens at enabled edge k, tvalid is high after enabled edge k+2·WIDTH+1, which is k+33 for WIDTH=16. It stays high for exactly one enabled cycle.
- Throughput is one result per 2·WIDTH+3 enabled cycles.
- tready is 0 from the edge after accept until return to IDLE. This includes the DONE cycle, so a requester still holding tvalid during DONE is not re-accepted.
- When clk_en=0, all registers hold, including tvalid. Latency therefore stretches by the number of disabled cycles.
- When rst_n falls at any time, including mid-CALC, the block enters IDLE immediately and all outputs are 0. tready rises once rst_n=1.

## Structure
- Package fixed_div_pkg contains:
  - the state enum (IDLE, CALC, FIX, DONE);
  - localparams for the saturation constants;
  - the iteration-counter width $clog2(2·WIDTH+1).
- Sub-module div_restore_step: a combinational single iteration. Its inputs are remainder, divisor and next numerator bit; its outputs are the new remainder and the quotient bit.
- The top level holds the FSM, the counter, the operand/quotient registers and the sign/saturation logic.

## Test plan
All scenarios use WIDTH=16.
- 0x0003 / 0x0002 → tdata 0x0001_8000, tuser 00, tvalid exactly 33 enabled edges after accept, one cycle wide.
- 0xFFF9 / 0x0002 → 0xFFFC_8000. 0x0001 / 0x0003 → 0x0000_5555. 0xFFFF / 0x0003 → 0xFFFF_AAAB (truncation toward zero).
- 0x0005 / 0x0000 → 0x7FFF_FFFF, tuser 10. 0x8000 / 0x0000 → 0x8000_0000, tuser 10. Both with the same latency as normal operations.
- 0x8000 / 0xFFFF → 0x7FFF_FFFF, tuser 01. 0x8000 / 0x0001 → 0x8000_0000, tuser 00. 0x4000 / 0x0001 → 0x4000_0000, tuser 00.
- Hold both tvalids high continuously → one accept per 35 cycles, none during DONE. Only one tvalid high → no accept. Randomly toggle clk_en during CALC → correct result, latency extended by the number of disabled cycles.
- Assert rst_n low mid-CALC → outputs 0 and tready low during reset; after release tready=1, and a new 0x0006 / 0x0003 returns 0x0002_0000 with no residue from the aborted operation.

Source files
------------

// File: rtl/axis_fixed_divider_pkg.sv
// Shared types and constants for the bit-serial signed fixed-point divider.
package fixed_div_pkg;

    localparam int DIV_WIDTH = 16;
    localparam int RES_WIDTH = 2 * DIV_WIDTH;
    localparam int CNT_W     = $clog2(RES_WIDTH + 1);

    // Saturation values for the Q(W).(W) result.
    localparam logic [RES_WIDTH-1:0] SAT_POS = {1'b0, {(RES_WIDTH-1){1'b1}}};
    localparam logic [RES_WIDTH-1:0] SAT_NEG = {1'b1, {(RES_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/axis_fixed_divider_if.sv
// Operand/result stream bundle of the divider, plus its FSM state for observation.
interface axis_fixed_divider_if #(parameter int WIDTH = 16);
    import fixed_div_pkg::*;

    // A request is taken on an enabled rising edge where both operand tvalids
    // and the shared tready are 1; the result is a one-cycle tvalid strobe
    // with no backpressure.
    logic [WIDTH-1:0]   s_axis_dividend_tdata;
    logic               s_axis_dividend_tvalid;
    logic [WIDTH-1:0]   s_axis_divisor_tdata;
    logic               s_axis_divisor_tvalid;
    logic               s_axis_tready;
    logic [2*WIDTH-1:0] m_axis_dout_tdata;
    logic [1:0]         m_axis_dout_tuser;
    logic               m_axis_dout_tvalid;
    state_t             dbg_state;

    modport slave (
        input  s_axis_dividend_tdata, s_axis_dividend_tvalid,
        input  s_axis_divisor_tdata, s_axis_divisor_tvalid,
        output s_axis_tready,
        output m_axis_dout_tdata, m_axis_dout_tuser, m_axis_dout_tvalid,
        output dbg_state
    );

    modport master (
        output s_axis_dividend_tdata, s_axis_dividend_tvalid,
        output s_axis_divisor_tdata, s_axis_divisor_tvalid,
        input  s_axis_tready,
        input  m_axis_dout_tdata, m_axis_dout_tuser, m_axis_dout_tvalid,
        input  dbg_state
    );

endinterface

// File: rtl/axis_fixed_divider_step.sv
// One restoring long-division iteration: shift in a numerator bit, subtract if it fits.
module div_restore_step #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH:0]   rem_i,
    input  logic [WIDTH-1:0] div_i,
    input  logic             num_bit_i,
    output logic [WIDTH:0]   rem_o,
    output logic             q_o
);

    logic [WIDTH+1:0] shifted;

    always_comb begin
        shifted = {rem_i, num_bit_i};
        q_o     = (shifted >= {2'b00, div_i});
        rem_o   = q_o ? (shifted[WIDTH:0] - {1'b0, div_i}) : shifted[WIDTH:0];
    end

endmodule

// File: rtl/axis_fixed_divider.sv
// Signed fixed-point divider: |a|*2^W / |b| by bit-serial restoring division, then sign and saturation.
module axis_fixed_divider
    import fixed_div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clk_en,
    axis_fixed_divider_if.slave  bus
);

    localparam int RW = 2 * WIDTH;
    localparam logic [RW-1:0]    MAX_POS  = SAT_POS[RW-1:0];
    localparam logic [RW-1:0]    MAX_NEG  = SAT_NEG[RW-1:0];
    localparam logic [CNT_W-1:0] LAST_IT  = CNT_W'(RW - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [RW-1:0]    num_q, num_d;
    logic [RW-1:0]    quo_q, quo_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic             neg_q, neg_d;
    logic             a_neg_q, a_neg_d;
    logic             dbz_q, dbz_d;
    logic [RW-1:0]    tdata_q, tdata_d;
    logic [1:0]       tuser_q, tuser_d;
    logic             tvalid_q, tvalid_d;

    logic [WIDTH-1:0] op_a, op_b, abs_a, abs_b;
    logic             tready, accept;
    logic [WIDTH:0]   step_rem;
    logic             step_bit;

    assign op_a   = bus.s_axis_dividend_tdata;
    assign op_b   = bus.s_axis_divisor_tdata;
    // Unsigned magnitude: the most negative operand maps onto itself (0x8000).
    assign abs_a  = op_a[WIDTH-1] ? -op_a : op_a;
    assign abs_b  = op_b[WIDTH-1] ? -op_b : op_b;
    assign tready = rst_n && (state_q == IDLE);
    assign accept = clk_en && tready &&
                    bus.s_axis_dividend_tvalid && bus.s_axis_divisor_tvalid;

    div_restore_step #(.WIDTH(WIDTH)) u_step (
        .rem_i     (rem_q),
        .div_i     (dvs_q),
        .num_bit_i (num_q[RW-1]),
        .rem_o     (step_rem),
        .q_o       (step_bit)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        num_d    = num_q;
        quo_d    = quo_q;
        rem_d    = rem_q;
        dvs_d    = dvs_q;
        neg_d    = neg_q;
        a_neg_d  = a_neg_q;
        dbz_d    = dbz_q;
        tdata_d  = tdata_q;
        tuser_d  = tuser_q;
        tvalid_d = tvalid_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    neg_d   = op_a[WIDTH-1] ^ op_b[WIDTH-1];
                    a_neg_d = op_a[WIDTH-1];
                    dbz_d   = (op_b == '0);
                    num_d   = {abs_a, {WIDTH{1'b0}}};
                    dvs_d   = abs_b;
                    rem_d   = '0;
                    quo_d   = '0;
                    cnt_d   = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                if (clk_en) begin
                    rem_d = step_rem;
                    quo_d = {quo_q[RW-2:0], step_bit};
                    num_d = {num_q[RW-2:0], 1'b0};
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_IT) begin
                        state_d = FIX;
                    end
                end
            end
            FIX: begin
                if (clk_en) begin
                    tvalid_d = 1'b1;
                    state_d  = DONE;
                    // Divide-by-zero wins over overflow and saturates toward the dividend's sign.
                    if (dbz_q) begin
                        tdata_d = a_neg_q ? MAX_NEG : MAX_POS;
                        tuser_d = 2'b10;
                    end else if (neg_q) begin
                        tdata_d = (quo_q > MAX_NEG) ? MAX_NEG : -quo_q;
                        tuser_d = {1'b0, (quo_q > MAX_NEG)};
                    end else begin
                        tdata_d = (quo_q >= MAX_NEG) ? MAX_POS : quo_q;
                        tuser_d = {1'b0, (quo_q >= MAX_NEG)};
                    end
                end
            end
            DONE: begin
                if (clk_en) begin
                    tvalid_d = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            num_q    <= '0;
            quo_q    <= '0;
            rem_q    <= '0;
            dvs_q    <= '0;
            neg_q    <= 1'b0;
            a_neg_q  <= 1'b0;
            dbz_q    <= 1'b0;
            tdata_q  <= '0;
            tuser_q  <= '0;
            tvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            num_q    <= num_d;
            quo_q    <= quo_d;
            rem_q    <= rem_d;
            dvs_q    <= dvs_d;
            neg_q    <= neg_d;
            a_neg_q  <= a_neg_d;
            dbz_q    <= dbz_d;
            tdata_q  <= tdata_d;
            tuser_q  <= tuser_d;
            tvalid_q <= tvalid_d;
        end
    end

    assign bus.s_axis_tready      = tready;
    assign bus.m_axis_dout_tdata  = tdata_q;
    assign bus.m_axis_dout_tuser  = tuser_q;
    assign bus.m_axis_dout_tvalid = tvalid_q;
    assign bus.dbg_state          = state_q;

endmodule
